ecc_scalar_mul_ctrl: RTL and testbench
======================================

Name: ecc_scalar_mul_ctrl

Overview:
- Sequencer for scalar multiplication Q = k·P over a short-Weierstrass prime curve.
- Walks the scalar MSB-to-LSB using left-to-right double-and-add.
- Issues double/add commands to one shared point-operation engine through a start/finish pulse handshake, and holds the running point R between operations.
- Sits between the ECDSA/ECDH top-level FSM and the point-operation engine.

Parameters:
- MAX_BITS, 256, width of the field element and of the scalar k.
- IDX_W, 9, width of the bit-index counter; must satisfy 2^IDX_W > MAX_BITS.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_start  in  1  one-cycle pulse; samples i_k, i_px, i_py. Honoured only in IDLE.
- i_k  in  MAX_BITS  scalar.
- i_px, i_py  in  MAX_BITS  base point; i_px all-ones encodes the point at infinity.
- o_busy  out  1  high from the cycle after an accepted i_start until o_finished.
- o_finished  out  1  one-cycle completion pulse.
- o_qx, o_qy  out  MAX_BITS  result; held until the next accepted start.
- o_op_start  out  1  one-cycle command pulse to the engine.
- o_op_sel  out  1  0 = double R, 1 = add R + P.
- o_op_x1, o_op_y1  out  MAX_BITS  operand R.
- o_op_x2, o_op_y2  out  MAX_BITS  operand P (latched base point).
- i_op_finished  in  1  engine completion pulse.
- i_op_x, i_op_y  in  MAX_BITS  engine result; valid when i_op_finished is high.

Behaviour:
- Reset values:
  - o_busy, o_finished, o_op_start, o_op_sel = 0.
  - o_qx, o_qy, o_op_* = 0.
  - State = IDLE, index = 0.
- Infinity is encoded as X = {MAX_BITS{1'b1}}, Y = 0.
- IDLE:
  - On i_start, latch k, P; set idx = MAX_BITS-1; go to SCAN.
  - If k == 0 or P is infinity: go directly to DONE with Q = infinity, P respectively. No engine commands are issued.
- SCAN:
  - Examines one bit per cycle.
  - If k[idx] == 1: R := P.
    - If idx == 0, go to DONE.
    - Otherwise idx--, go to DBL_ISSUE.
  - If k[idx] == 0: idx-- and stay in SCAN.
  - SCAN cannot underflow, because k != 0 is guaranteed on entry.
- DBL_ISSUE: pulse o_op_start with o_op_sel = 0; go to DBL_WAIT.
- DBL_WAIT:
  - On i_op_finished: R := (i_op_x, i_op_y).
  - If k[idx] == 1, go to ADD_ISSUE.
  - Otherwise: if idx == 0 go to DONE, else idx-- and go to DBL_ISSUE.
- ADD_ISSUE: pulse o_op_start with o_op_sel = 1; go to ADD_WAIT.
- ADD_WAIT:
  - On i_op_finished: R := result.
  - If idx == 0 go to DONE, else idx-- and go to DBL_ISSUE.
- DONE:
  - o_qx/o_qy := R; o_finished pulses for one cycle.
  - o_busy falls in the same cycle; go to IDLE.
  - A new i_start is accepted in the following cycle.
- Operand outputs are registered and stable from o_op_start until i_op_finished.
- i_op_finished outside the *_WAIT states is ignored.
- o_op_start is never asserted while the engine is busy; at most one outstanding command.
- i_start while busy is ignored; latched operands are unaffected.
- Operation count: (bitlen(k) − 1) doubles plus (popcount(k) − 1) adds.
- Controller overhead per operation: 1 issue cycle. Scan cost: (MAX_BITS − bitlen(k)) + 1 cycles.
- i_rst mid-operation: return to IDLE immediately, clear o_op_start, discard R. The engine must be reset by the same i_rst.

Optional Feature:
- Macro ECC_CONST_TIME_EN.
- Defined:
  - An add is issued after every double regardless of k[idx]. Its result is written to R only when k[idx] == 1 and is discarded otherwise.
  - SCAN always runs the full MAX_BITS cycles; the first set bit is recorded, not jumped to.
  - Op count then depends only on bitlen(k), and scan time is constant.
- Undefined: behaviour as above (adds only on set bits, early scan exit).

Decomposition:
- Package ecc_ctrl_pkg holds:
  - state encoding: IDLE, SCAN, DBL_ISSUE, DBL_WAIT, ADD_ISSUE, ADD_WAIT, DONE;
  - OP_DBL = 1'b0, OP_ADD = 1'b1;
  - INF_X = {MAX_BITS{1'b1}};
  - MAX_BITS, taken from the shared ECC define file.
- No sub-module; the bit index and scan are a counter inside the FSM. The engine is external.

Test Plan:
- Curve for all scenarios: y² = x³+2x+2 mod 17, P = (5,1). The bench engine is a behavioural model with random 3–20 cycle latency.
- k=0 -> no o_op_start; o_finished within 3 cycles; Q = (all-ones, 0).
- k=1 -> zero ops; Q = (5,1); scan takes MAX_BITS cycles.
- k=2 -> exactly one op (DBL); Q = (6,3).
- k=5 (101b) -> sequence DBL, DBL, ADD; Q = (9,16). With ECC_CONST_TIME_EN: DBL, ADD(discarded), DBL, ADD; same Q.
- k=5, second i_start pulsed during DBL_WAIT -> ignored; single o_finished; Q = (9,16).
- k=5, i_rst asserted during ADD_WAIT, then engine asserts i_op_finished after reset release -> all outputs 0, state IDLE, spurious finish ignored; a fresh k=3 run gives Q = (10,6).

Source files
------------

// File: rtl/ecc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ecc_ctrl_pkg
// Shared definitions for the ECC scalar-multiplication sequencer:
//   - MAX_BITS : field-element / scalar width, from the ECC-wide define
//                ECC_MAX_BITS (falls back to 256 when not supplied)
//   - ctrl_state_e : sequencer state encoding
//   - OP_DBL / OP_ADD : point-engine operation selectors
//   - INF_X : X coordinate that encodes the point at infinity (Y = 0)
// ---------------------------------------------------------------------------
`ifndef ECC_MAX_BITS
`define ECC_MAX_BITS 256
`endif

package ecc_ctrl_pkg;

  localparam int MAX_BITS = `ECC_MAX_BITS;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SCAN      = 3'd1,
    DBL_ISSUE = 3'd2,
    DBL_WAIT  = 3'd3,
    ADD_ISSUE = 3'd4,
    ADD_WAIT  = 3'd5,
    DONE      = 3'd6
  } ctrl_state_e;

  localparam logic OP_DBL = 1'b0;
  localparam logic OP_ADD = 1'b1;

  localparam logic [MAX_BITS-1:0] INF_X = {MAX_BITS{1'b1}};

endpackage

// File: rtl/ecc_scalar_mul_ctrl.sv
// ---------------------------------------------------------------------------
// ecc_scalar_mul_ctrl
// Left-to-right double-and-add sequencer computing Q = k*P. It scans the
// scalar MSB first, then drives one external point engine through a
// start/finish pulse handshake, keeping the running point R locally.
//
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_start                 one-cycle request; samples i_k/i_px/i_py in IDLE
//   i_k, i_px, i_py         scalar and base point (i_px all-ones = infinity)
//   o_busy                  high from the cycle after acceptance to o_finished
//   o_finished              one-cycle completion pulse
//   o_qx, o_qy              result, held until the next accepted start
//   o_op_start, o_op_sel    engine command pulse, 0 = double R, 1 = add R+P
//   o_op_x1/y1, o_op_x2/y2  engine operands R and P, stable while outstanding
//   i_op_finished           engine completion pulse
//   i_op_x, i_op_y          engine result, valid with i_op_finished
//
// Build option: define ECC_CONST_TIME_EN for a constant-pattern schedule
// (an add after every double, full-length scan).
// IDX_W must satisfy 2**IDX_W > MAX_BITS.
// ---------------------------------------------------------------------------
module ecc_scalar_mul_ctrl #(
  parameter int MAX_BITS = ecc_ctrl_pkg::MAX_BITS,
  parameter int IDX_W    = 9
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [MAX_BITS-1:0] i_k,
  input  logic [MAX_BITS-1:0] i_px,
  input  logic [MAX_BITS-1:0] i_py,
  output logic                o_busy,
  output logic                o_finished,
  output logic [MAX_BITS-1:0] o_qx,
  output logic [MAX_BITS-1:0] o_qy,
  output logic                o_op_start,
  output logic                o_op_sel,
  output logic [MAX_BITS-1:0] o_op_x1,
  output logic [MAX_BITS-1:0] o_op_y1,
  output logic [MAX_BITS-1:0] o_op_x2,
  output logic [MAX_BITS-1:0] o_op_y2,
  input  logic                i_op_finished,
  input  logic [MAX_BITS-1:0] i_op_x,
  input  logic [MAX_BITS-1:0] i_op_y
);

  import ecc_ctrl_pkg::*;

  localparam int SEL_W = $clog2(MAX_BITS);
  localparam logic [MAX_BITS-1:0] INF_PT_X = {MAX_BITS{1'b1}};
  localparam logic [MAX_BITS-1:0] ZERO_W   = {MAX_BITS{1'b0}};
  localparam logic [IDX_W-1:0]    IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0]    IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0]    IDX_TOP  = IDX_W'(MAX_BITS - 1);

  function automatic logic is_inf(input logic [MAX_BITS-1:0] x);
    return (x == INF_PT_X);
  endfunction

  ctrl_state_e         state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [MAX_BITS-1:0] k_q, k_d;
  logic [MAX_BITS-1:0] px_q, px_d, py_q, py_d;
  logic [MAX_BITS-1:0] rx_q, rx_d, ry_q, ry_d;
  logic [MAX_BITS-1:0] qx_q, qx_d, qy_q, qy_d;
  logic                busy_q, busy_d;
  logic                finished_q, finished_d;
  logic                op_start_q, op_start_d;
  logic                op_sel_q, op_sel_d;
  logic [MAX_BITS-1:0] op_x1_q, op_x1_d, op_y1_q, op_y1_d;
  logic [MAX_BITS-1:0] op_x2_q, op_x2_d, op_y2_q, op_y2_d;
`ifdef ECC_CONST_TIME_EN
  logic                found_q, found_d;
  logic [IDX_W-1:0]    msb_q, msb_d;
`endif

  logic k_bit_s;
  assign k_bit_s = k_q[idx_q[SEL_W-1:0]];

  // Next-state, datapath and output computation for the sequencer.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    k_d        = k_q;
    px_d       = px_q;
    py_d       = py_q;
    rx_d       = rx_q;
    ry_d       = ry_q;
    qx_d       = qx_q;
    qy_d       = qy_q;
    busy_d     = busy_q;
    finished_d = 1'b0;
    op_start_d = 1'b0;
    op_sel_d   = op_sel_q;
    op_x1_d    = op_x1_q;
    op_y1_d    = op_y1_q;
    op_x2_d    = op_x2_q;
    op_y2_d    = op_y2_q;
`ifdef ECC_CONST_TIME_EN
    found_d    = found_q;
    msb_d      = msb_q;
`endif

    case (state_q)
      IDLE: begin
        if (i_start) begin
          k_d    = i_k;
          px_d   = i_px;
          py_d   = i_py;
          idx_d  = IDX_TOP;
          busy_d = 1'b1;
`ifdef ECC_CONST_TIME_EN
          found_d = 1'b0;
          msb_d   = IDX_ZERO;
`endif
          // Trivial products bypass the engine entirely.
          if (i_k == ZERO_W) begin
            rx_d    = INF_PT_X;
            ry_d    = ZERO_W;
            state_d = DONE;
          end else if (is_inf(i_px)) begin
            rx_d    = i_px;
            ry_d    = i_py;
            state_d = DONE;
          end else begin
            state_d = SCAN;
          end
        end else begin
          state_d = IDLE;
        end
      end

      SCAN: begin
`ifdef ECC_CONST_TIME_EN
        // Full-length scan: remember the leading one, keep walking.
        if (k_bit_s && !found_q) begin
          found_d = 1'b1;
          msb_d   = idx_q;
          rx_d    = px_q;
          ry_d    = py_q;
        end else begin
          found_d = found_q;
        end
        if (idx_q == IDX_ZERO) begin
          // k is non-zero, so an unset found_q means bit 0 is the leading one.
          if (found_q && (msb_q != IDX_ZERO)) begin
            idx_d   = msb_q - IDX_ONE;
            state_d = DBL_ISSUE;
          end else begin
            state_d = DONE;
          end
        end else begin
          idx_d = idx_q - IDX_ONE;
        end
`else
        if (k_bit_s) begin
          rx_d = px_q;
          ry_d = py_q;
          if (idx_q == IDX_ZERO) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q - IDX_ONE;
            state_d = DBL_ISSUE;
          end
        end else begin
          idx_d = idx_q - IDX_ONE;
        end
`endif
      end

      DBL_ISSUE: begin
        op_start_d = 1'b1;
        op_sel_d   = OP_DBL;
        op_x1_d    = rx_q;
        op_y1_d    = ry_q;
        op_x2_d    = px_q;
        op_y2_d    = py_q;
        state_d    = DBL_WAIT;
      end

      DBL_WAIT: begin
        if (i_op_finished) begin
          rx_d = i_op_x;
          ry_d = i_op_y;
`ifdef ECC_CONST_TIME_EN
          state_d = ADD_ISSUE;
`else
          if (k_bit_s) begin
            state_d = ADD_ISSUE;
          end else if (idx_q == IDX_ZERO) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q - IDX_ONE;
            state_d = DBL_ISSUE;
          end
`endif
        end else begin
          state_d = DBL_WAIT;
        end
      end

      ADD_ISSUE: begin
        op_start_d = 1'b1;
        op_sel_d   = OP_ADD;
        op_x1_d    = rx_q;
        op_y1_d    = ry_q;
        op_x2_d    = px_q;
        op_y2_d    = py_q;
        state_d    = ADD_WAIT;
      end

      ADD_WAIT: begin
        if (i_op_finished) begin
`ifdef ECC_CONST_TIME_EN
          // Dummy adds on clear bits still run; their result is dropped.
          if (k_bit_s) begin
            rx_d = i_op_x;
            ry_d = i_op_y;
          end else begin
            rx_d = rx_q;
            ry_d = ry_q;
          end
`else
          rx_d = i_op_x;
          ry_d = i_op_y;
`endif
          if (idx_q == IDX_ZERO) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q - IDX_ONE;
            state_d = DBL_ISSUE;
          end
        end else begin
          state_d = ADD_WAIT;
        end
      end

      DONE: begin
        qx_d       = rx_q;
        qy_d       = ry_q;
        finished_d = 1'b1;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any run and discards R.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      idx_q      <= IDX_ZERO;
      k_q        <= ZERO_W;
      px_q       <= ZERO_W;
      py_q       <= ZERO_W;
      rx_q       <= ZERO_W;
      ry_q       <= ZERO_W;
      qx_q       <= ZERO_W;
      qy_q       <= ZERO_W;
      busy_q     <= 1'b0;
      finished_q <= 1'b0;
      op_start_q <= 1'b0;
      op_sel_q   <= 1'b0;
      op_x1_q    <= ZERO_W;
      op_y1_q    <= ZERO_W;
      op_x2_q    <= ZERO_W;
      op_y2_q    <= ZERO_W;
`ifdef ECC_CONST_TIME_EN
      found_q    <= 1'b0;
      msb_q      <= IDX_ZERO;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      k_q        <= k_d;
      px_q       <= px_d;
      py_q       <= py_d;
      rx_q       <= rx_d;
      ry_q       <= ry_d;
      qx_q       <= qx_d;
      qy_q       <= qy_d;
      busy_q     <= busy_d;
      finished_q <= finished_d;
      op_start_q <= op_start_d;
      op_sel_q   <= op_sel_d;
      op_x1_q    <= op_x1_d;
      op_y1_q    <= op_y1_d;
      op_x2_q    <= op_x2_d;
      op_y2_q    <= op_y2_d;
`ifdef ECC_CONST_TIME_EN
      found_q    <= found_d;
      msb_q      <= msb_d;
`endif
    end
  end

  assign o_busy     = busy_q;
  assign o_finished = finished_q;
  assign o_qx       = qx_q;
  assign o_qy       = qy_q;
  assign o_op_start = op_start_q;
  assign o_op_sel   = op_sel_q;
  assign o_op_x1    = op_x1_q;
  assign o_op_y1    = op_y1_q;
  assign o_op_x2    = op_x2_q;
  assign o_op_y2    = op_y2_q;

endmodule

// File: tb/tb_ecc_scalar_mul_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ecc_scalar_mul_ctrl
// Drives ecc_scalar_mul_ctrl on the curve y^2 = x^3 + 2x + 2 mod 17 with base
// point (5,1). A behavioural point engine answers commands after a random
// 3..20 cycle latency. Expected products come from plain repeated point
// addition; expected command sequences come from the bits of k.
// ---------------------------------------------------------------------------
module tb_ecc_scalar_mul_ctrl;

  localparam int MB      = 256;
  localparam int PRIME   = 17;
  localparam int CURVE_A = 2;
  localparam int BOUND   = 20000;
`ifdef ECC_CONST_TIME_EN
  localparam bit CT = 1'b1;
`else
  localparam bit CT = 1'b0;
`endif
  localparam logic [MB-1:0] ALL1 = {MB{1'b1}};

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start;
  logic [MB-1:0] i_k, i_px, i_py;
  logic          o_busy, o_finished, o_op_start, o_op_sel;
  logic [MB-1:0] o_qx, o_qy, o_op_x1, o_op_y1, o_op_x2, o_op_y2;
  logic          i_op_finished;
  logic [MB-1:0] i_op_x, i_op_y;

  int passed = 0;
  int total  = 0;

  int   eng_fixed_lat = 0;
  bit   eng_pending   = 1'b0;
  logic eng_sel       = 1'b0;
  bit   eng_log[$];

  always #5 clk = ~clk;

  ecc_scalar_mul_ctrl #(.MAX_BITS(MB), .IDX_W(9)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_k(i_k), .i_px(i_px), .i_py(i_py),
    .o_busy(o_busy), .o_finished(o_finished), .o_qx(o_qx), .o_qy(o_qy),
    .o_op_start(o_op_start), .o_op_sel(o_op_sel),
    .o_op_x1(o_op_x1), .o_op_y1(o_op_y1), .o_op_x2(o_op_x2), .o_op_y2(o_op_y2),
    .i_op_finished(i_op_finished), .i_op_x(i_op_x), .i_op_y(i_op_y)
  );

  task automatic check(input string tag, input logic [MB-1:0] obs, input logic [MB-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int md(input int v);
    int r;
    r = v % PRIME;
    if (r < 0) r = r + PRIME;
    return r;
  endfunction

  function automatic int inv(input int v);
    for (int i = 1; i < PRIME; i++) if (md(v * i) == 1) return i;
    return 0;
  endfunction

  // Affine point addition; x = -1 stands for the point at infinity.
  function automatic void ec_add(input int x1, input int y1, input int x2, input int y2,
                                 output int x3, output int y3);
    int lam;
    if (x1 < 0) begin
      x3 = x2; y3 = y2;
    end else if (x2 < 0) begin
      x3 = x1; y3 = y1;
    end else if (x1 == x2 && md(y1 + y2) == 0) begin
      x3 = -1; y3 = 0;
    end else begin
      if (x1 == x2) lam = md((3 * x1 * x1 + CURVE_A) * inv(2 * y1));
      else          lam = md((y2 - y1) * inv(x2 - x1));
      x3 = md(lam * lam - x1 - x2);
      y3 = md(lam * (x1 - x3) - y1);
    end
  endfunction

  function automatic int to_i(input logic [MB-1:0] v);
    return (v === ALL1) ? -1 : int'(v[31:0]);
  endfunction

  function automatic logic [MB-1:0] to_v(input int v);
    return (v < 0) ? ALL1 : MB'(v);
  endfunction

  // k*B by repeated addition of B, with k reduced modulo the order of B.
  function automatic void ref_mul(input logic [MB-1:0] k, input int bx, input int by,
                                  output int ex, output int ey);
    int ord, cx, cy, r;
    ex = -1; ey = 0;
    if (bx >= 0) begin
      ord = 1; cx = bx; cy = by;
      while (cx >= 0 && ord < 1000) begin
        ec_add(cx, cy, bx, by, cx, cy);
        ord++;
      end
      r = 0;
      for (int i = MB - 1; i >= 0; i--) r = (r * 2 + int'(k[i])) % ord;
      repeat (r) ec_add(ex, ey, bx, by, ex, ey);
    end
  endfunction

  // Behavioural point engine.
  initial begin
    i_op_finished = 1'b0;
    i_op_x = '0;
    i_op_y = '0;
    forever begin : eng_body
      int lat, rx, ry;
      logic sel;
      @(negedge clk);
      if (o_op_start === 1'b1) begin
        sel = o_op_sel;
        eng_log.push_back(sel);
        eng_sel = sel;
        eng_pending = 1'b1;
        lat = (eng_fixed_lat > 0) ? eng_fixed_lat : $urandom_range(20, 3);
        repeat (lat - 1) @(negedge clk);
        if (sel) ec_add(to_i(o_op_x1), to_i(o_op_y1), to_i(o_op_x2), to_i(o_op_y2), rx, ry);
        else     ec_add(to_i(o_op_x1), to_i(o_op_y1), to_i(o_op_x1), to_i(o_op_y1), rx, ry);
        i_op_x = to_v(rx);
        i_op_y = (rx < 0) ? '0 : to_v(ry);
        i_op_finished = 1'b1;
        @(negedge clk);
        i_op_finished = 1'b0;
        eng_pending = 1'b0;
      end
    end
  end

  task automatic run_k(input string tag, input logic [MB-1:0] k, input logic [MB-1:0] px,
                       input logic [MB-1:0] py, input bit poke, output int lat);
    int  base, extra, ex, ey, top, mism, n;
    bit  poked;
    bit  exp_seq[$];
    base  = eng_log.size();
    poked = 1'b0;
    ref_mul(k, to_i(px), to_i(py), ex, ey);
    top = -1;
    for (int i = 0; i < MB; i++) if (k[i]) top = i;
    if (px !== ALL1) begin
      for (int i = top - 1; i >= 0; i--) begin
        exp_seq.push_back(1'b0);
        if (CT || k[i]) exp_seq.push_back(1'b1);
      end
    end
    i_k = k; i_px = px; i_py = py; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_k = MB'($urandom); i_px = MB'($urandom); i_py = MB'($urandom);
    lat = 1;
    check({tag, "_busy"}, MB'(o_busy), MB'(1));
    while (o_finished !== 1'b1 && lat < BOUND) begin
      if (poke && !poked && eng_pending && eng_sel == 1'b0) begin
        i_start = 1'b1; i_k = MB'(7); i_px = MB'(6); i_py = MB'(3);
        poked = 1'b1;
      end
      @(negedge clk);
      i_start = 1'b0;
      lat++;
    end
    check({tag, "_finished"}, MB'(o_finished), MB'(1));
    check({tag, "_busy_low"}, MB'(o_busy), MB'(0));
    check({tag, "_qx"}, o_qx, to_v(ex));
    check({tag, "_qy"}, o_qy, (ex < 0) ? ((px === ALL1) ? py : '0) : to_v(ey));
    n = eng_log.size() - base;
    check({tag, "_nops"}, MB'(n), MB'(exp_seq.size()));
    mism = 0;
    for (int i = 0; i < n && i < exp_seq.size(); i++)
      if (eng_log[base + i] != exp_seq[i]) mism++;
    check({tag, "_opseq"}, MB'(mism), MB'(0));
    if (poke) check({tag, "_poked"}, MB'(poked), MB'(1));
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (o_finished === 1'b1 || o_op_start === 1'b1) extra++;
    end
    check({tag, "_quiet"}, MB'(extra), MB'(0));
    check({tag, "_qhold"}, o_qx, to_v(ex));
  endtask

  initial begin
    int lat, w, extra;
    rst = 1'b1; i_start = 1'b0; i_k = '0; i_px = '0; i_py = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", MB'(o_busy), MB'(0));
    check("rst_finished", MB'(o_finished), MB'(0));
    check("rst_op_start", MB'(o_op_start), MB'(0));
    check("rst_op_sel", MB'(o_op_sel), MB'(0));
    check("rst_q", o_qx | o_qy, '0);
    check("rst_ops", o_op_x1 | o_op_y1 | o_op_x2 | o_op_y2, '0);
    rst = 1'b0;
    @(negedge clk);

    run_k("k0", MB'(0), MB'(5), MB'(1), 1'b0, lat);
    check("k0_lat", MB'(lat <= 3), MB'(1));
    run_k("k1", MB'(1), MB'(5), MB'(1), 1'b0, lat);
    check("k1_lat", MB'(lat), MB'(MB + 2));
    run_k("k2", MB'(2), MB'(5), MB'(1), 1'b0, lat);
    run_k("k5", MB'(5), MB'(5), MB'(1), 1'b0, lat);
    run_k("k5_poke", MB'(5), MB'(5), MB'(1), 1'b1, lat);
    run_k("pinf", MB'(5), ALL1, MB'(0), 1'b0, lat);
    repeat (3) run_k("rand32", MB'($urandom), MB'(5), MB'(1), 1'b0, lat);
    run_k("randfull", {$urandom, $urandom, $urandom, $urandom,
                       $urandom, $urandom, $urandom, $urandom}, MB'(5), MB'(1), 1'b0, lat);

    // Reset while an add is outstanding; the late engine finish must be ignored.
    eng_fixed_lat = 20;
    i_k = MB'(5); i_px = MB'(5); i_py = MB'(1); i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    w = 0;
    while (!(eng_pending && eng_sel == 1'b1) && w < BOUND) begin
      @(negedge clk);
      w++;
    end
    check("rst_reach_add", MB'(eng_pending && eng_sel == 1'b1), MB'(1));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("midrst_busy", MB'(o_busy), MB'(0));
    check("midrst_op_start", MB'(o_op_start), MB'(0));
    check("midrst_op_sel", MB'(o_op_sel), MB'(0));
    check("midrst_ops", o_op_x1 | o_op_y1 | o_op_x2 | o_op_y2, '0);
    rst = 1'b0;
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (o_finished === 1'b1 || o_op_start === 1'b1 || o_busy === 1'b1) extra++;
    end
    check("midrst_quiet", MB'(extra), MB'(0));
    check("midrst_spurious_sent", MB'(eng_pending), MB'(0));
    check("midrst_q", o_qx | o_qy, '0);
    eng_fixed_lat = 0;
    run_k("k3", MB'(3), MB'(5), MB'(1), 1'b0, lat);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
